// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice: opcodes, FSM encoding and
// requester identifiers.
package alu_arbiter_pkg;

   // Bitwise opcodes; every legal opcode has op[3:2] == 2'b01.
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0110;
   localparam logic [3:0] OP_NOR = 4'b0111;

   // Two-bit FSM encoding; 2'b11 is unused and falls back to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

   // Requester identifiers.
   localparam int PORT_ID_W = 1;
   typedef logic [PORT_ID_W-1:0] port_id_t;
   localparam port_id_t PORT0 = port_id_t'(0);
   localparam port_id_t PORT1 = port_id_t'(1);

   // The requester that was not just served gets priority next.
   function automatic port_id_t otherPort(input port_id_t id);
      return (id == PORT0) ? PORT1 : PORT0;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and the ALU arbiter.
interface alu_arbiter_if #(
   parameter int WIDTH = 32
) ();

   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [3:0]       req0_op;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [3:0]       req1_op;

   logic             rsp0_valid;
   logic             rsp0_ready;
   logic [WIDTH-1:0] rsp0_result;
   logic             rsp0_err;
   logic             rsp1_valid;
   logic             rsp1_ready;
   logic [WIDTH-1:0] rsp1_result;
   logic             rsp1_err;

   // Requester side: issues operations and consumes results.
   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_result, rsp0_err,
      input  rsp1_valid, rsp1_result, rsp1_err,
      output rsp0_ready, rsp1_ready
   );

   // Arbiter side: accepts operations and presents results.
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_result, rsp0_err,
      output rsp1_valid, rsp1_result, rsp1_err,
      input  rsp0_ready, rsp1_ready
   );

endinterface

// File: rtl/alu_logic_unit.sv
// Shared combinational bitwise unit; non-logic opcodes yield zero plus err.
module alu_logic_unit
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [3:0]       op_i,
   output logic [WIDTH-1:0] result_o,
   output logic             err_o
);

   // Decode the opcode; anything outside the logic class is an error.
   always_comb begin
      result_o = '0;
      err_o    = 1'b1;
      case (op_i)
         OP_AND: begin
            result_o = a_i & b_i;
            err_o    = 1'b0;
         end
         OP_OR: begin
            result_o = a_i | b_i;
            err_o    = 1'b0;
         end
         OP_XOR: begin
            result_o = a_i ^ b_i;
            err_o    = 1'b0;
         end
         OP_NOR: begin
            result_o = ~(a_i | b_i);
            err_o    = 1'b0;
         end
         default: begin
            result_o = '0;
            err_o    = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared bitwise logic unit.
// A request handshaken in cycle N is latched at the end of that cycle,
// executes in cycle N+1 and its result is presented from cycle N+2 until
// the owning requester takes it.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_arbiter_if.slave bus,
   output logic         busy
);

   state_t           state_q, state_d;
   port_id_t         prio_q, prio_d;
   port_id_t         grant_q, grant_d;
   port_id_t         grantSel;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             err_q, err_d;
   logic             accept;
   logic [WIDTH-1:0] selA;
   logic [WIDTH-1:0] selB;
   logic [3:0]       selOp;
   logic             rspReadySel;
   logic [WIDTH-1:0] aluResult;
   logic             aluErr;

   // A lone requester wins outright; under contention the prio port wins.
   always_comb begin
      grantSel = prio_q;
      if (bus.req0_valid && !bus.req1_valid) begin
         grantSel = PORT0;
      end else if (bus.req1_valid && !bus.req0_valid) begin
         grantSel = PORT1;
      end
   end

   // Ready is offered only in IDLE, out of reset, to the granted requester.
   always_comb begin
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      if ((state_q == IDLE) && rst_n) begin
         bus.req0_ready = bus.req0_valid && (grantSel == PORT0);
         bus.req1_ready = bus.req1_valid && (grantSel == PORT1);
      end
   end

   // Steer the granted requester's operation toward the latch.
   always_comb begin
      accept      = bus.req0_ready || bus.req1_ready;
      selA        = (grantSel == PORT1) ? bus.req1_a  : bus.req0_a;
      selB        = (grantSel == PORT1) ? bus.req1_b  : bus.req0_b;
      selOp       = (grantSel == PORT1) ? bus.req1_op : bus.req0_op;
      rspReadySel = (grant_q == PORT1) ? bus.rsp1_ready : bus.rsp0_ready;
   end

   alu_logic_unit #(
      .WIDTH (WIDTH)
   ) u_logic (
      .a_i      (a_q),
      .b_i      (b_q),
      .op_i     (op_q),
      .result_o (aluResult),
      .err_o    (aluErr)
   );

   // Next-state logic: latch on accept, register the result in EXEC, and
   // hand priority to the other port once the response is taken.
   always_comb begin
      state_d  = state_q;
      prio_d   = prio_q;
      grant_d  = grant_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               grant_d = grantSel;
               a_d     = selA;
               b_d     = selB;
               op_d    = selOp;
               state_d = EXEC;
            end
         end
         EXEC: begin
            result_d = aluResult;
            err_d    = aluErr;
            state_d  = RESP;
         end
         RESP: begin
            if (rspReadySel) begin
               prio_d  = otherPort(grant_q);
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any in-flight transaction.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         prio_q   <= PORT0;
         grant_q  <= PORT0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         grant_q  <= grant_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   // Present the held result only toward the port that owns it.
   always_comb begin
      bus.rsp0_valid  = (state_q == RESP) && (grant_q == PORT0);
      bus.rsp1_valid  = (state_q == RESP) && (grant_q == PORT1);
      bus.rsp0_result = result_q;
      bus.rsp1_result = result_q;
      bus.rsp0_err    = err_q;
      bus.rsp1_err    = err_q;
      busy            = (state_q != IDLE);
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomised bench for alu_arbiter.
module tb_alu_arbiter;

   typedef struct {
      int          port;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expResult;
      logic        expErr;
   } vec_t;

   logic clk;
   logic rst_n;
   logic busy;
   int   checks;
   int   errors;

   vec_t        vecs[7];
   logic [31:0] rA[2];
   logic [31:0] rB[2];
   logic [3:0]  rOp[2];
   logic        pending[2];
   logic [31:0] expRes[2];
   logic        expErr[2];
   logic        acc[2];
   int          waitCnt[2];
   int          stallCnt[2];
   logic        prioModel;
   logic [32:0] modelOut;

   alu_arbiter_if #(.WIDTH(32)) bus ();

   alu_arbiter #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .busy  (busy)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Independent reference of the logic unit: {err, result}.
   function automatic logic [32:0] modelAlu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      case (op)
         4'b0100: return {1'b0, a & b};
         4'b0101: return {1'b0, a | b};
         4'b0110: return {1'b0, a ^ b};
         4'b0111: return {1'b0, ~(a | b)};
         default: return {1'b1, 32'h0};
      endcase
   endfunction

   function automatic logic readyOf(input int p);
      return (p == 0) ? bus.req0_ready : bus.req1_ready;
   endfunction

   function automatic logic rspValidOf(input int p);
      return (p == 0) ? bus.rsp0_valid : bus.rsp1_valid;
   endfunction

   function automatic logic [31:0] rspResultOf(input int p);
      return (p == 0) ? bus.rsp0_result : bus.rsp1_result;
   endfunction

   function automatic logic rspErrOf(input int p);
      return (p == 0) ? bus.rsp0_err : bus.rsp1_err;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic checkFlag(input string name, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int port, input logic valid, input logic [31:0] a,
                                input logic [31:0] b, input logic [3:0] op);
      if (port == 0) begin
         bus.req0_valid = valid;
         bus.req0_a     = a;
         bus.req0_b     = b;
         bus.req0_op    = op;
      end else begin
         bus.req1_valid = valid;
         bus.req1_a     = a;
         bus.req1_b     = b;
         bus.req1_op    = op;
      end
   endtask

   task automatic stepToDrive();
      @(posedge clk);
      #1;
   endtask

   task automatic stepToSample();
      @(negedge clk);
   endtask

   // One lone transaction with full cycle-by-cycle checking.
   task automatic runVector(input vec_t v, input int idx);
      stepToDrive();
      applyStimulus(v.port, 1'b1, v.a, v.b, v.op);
      bus.rsp0_ready = 1'b1;
      bus.rsp1_ready = 1'b1;
      stepToSample();
      checkFlag($sformatf("vec%0d ready", idx), readyOf(v.port), 1'b1);
      checkFlag($sformatf("vec%0d other ready", idx), readyOf(1 - v.port), 1'b0);
      stepToDrive();
      applyStimulus(v.port, 1'b0, v.a, v.b, v.op);
      stepToSample();
      checkFlag($sformatf("vec%0d exec busy", idx), busy, 1'b1);
      checkFlag($sformatf("vec%0d exec rsp_valid", idx), rspValidOf(v.port), 1'b0);
      stepToDrive();
      stepToSample();
      checkFlag($sformatf("vec%0d rsp_valid", idx), rspValidOf(v.port), 1'b1);
      checkFlag($sformatf("vec%0d other rsp_valid", idx), rspValidOf(1 - v.port), 1'b0);
      checkOutput($sformatf("vec%0d result", idx), rspResultOf(v.port), v.expResult);
      checkFlag($sformatf("vec%0d err", idx), rspErrOf(v.port), v.expErr);
      stepToDrive();
      stepToSample();
      checkFlag($sformatf("vec%0d idle busy", idx), busy, 1'b0);
      checkFlag($sformatf("vec%0d idle rsp_valid", idx), rspValidOf(v.port), 1'b0);
   endtask

   task automatic newRandomReq(input int p);
      rA[p]  = $urandom();
      rB[p]  = $urandom();
      rOp[p] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                           : 4'($urandom_range(4, 7));
      applyStimulus(p, 1'b1, rA[p], rB[p], rOp[p]);
   endtask

   initial begin
      checks = 0;
      errors = 0;

      vecs[0] = '{0, 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
      vecs[1] = '{0, 4'b0101, 32'h1234_5678, 32'h0F0F_0000, 32'h1F3F_5678, 1'b0};
      vecs[2] = '{1, 4'b0110, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0};
      vecs[3] = '{1, 4'b0111, 32'h0000_FFFF, 32'h00FF_0000, 32'hFF00_0000, 1'b0};
      vecs[4] = '{1, 4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
      vecs[5] = '{0, 4'b1100, 32'h1234_5678, 32'h8765_4321, 32'h0000_0000, 1'b1};
      vecs[6] = '{0, 4'b0111, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};

      // Reset with a request pending: ready must stay low.
      rst_n          = 1'b0;
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
      applyStimulus(0, 1'b1, 32'h1, 32'h2, 4'b0100);
      applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'b0000);
      repeat (2) @(posedge clk);
      stepToSample();
      checkFlag("reset req0_ready", bus.req0_ready, 1'b0);
      checkFlag("reset busy", busy, 1'b0);
      checkFlag("reset rsp0_valid", bus.rsp0_valid, 1'b0);
      checkFlag("reset rsp1_valid", bus.rsp1_valid, 1'b0);
      checkOutput("reset rsp0_result", bus.rsp0_result, 32'h0);
      checkFlag("reset rsp1_err", bus.rsp1_err, 1'b0);

      // Contention right after reset: port 0, then port 1, then port 0.
      stepToDrive();
      rst_n = 1'b1;
      applyStimulus(0, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0100);
      applyStimulus(1, 1'b1, 32'h0, 32'h0, 4'b0111);
      bus.rsp0_ready = 1'b1;
      bus.rsp1_ready = 1'b1;
      stepToSample();
      checkFlag("cont1 ready0", bus.req0_ready, 1'b1);
      checkFlag("cont1 ready1", bus.req1_ready, 1'b0);
      stepToDrive();
      stepToSample();
      checkFlag("cont1 exec ready0", bus.req0_ready, 1'b0);
      checkFlag("cont1 exec ready1", bus.req1_ready, 1'b0);
      stepToDrive();
      stepToSample();
      checkFlag("cont1 rsp0_valid", bus.rsp0_valid, 1'b1);
      checkFlag("cont1 rsp1_valid", bus.rsp1_valid, 1'b0);
      checkOutput("cont1 result", bus.rsp0_result, 32'hF000_F000);
      stepToDrive();
      stepToSample();
      checkFlag("cont2 ready1", bus.req1_ready, 1'b1);
      checkFlag("cont2 ready0", bus.req0_ready, 1'b0);
      stepToDrive();
      stepToSample();
      checkFlag("cont2 exec busy", busy, 1'b1);
      stepToDrive();
      stepToSample();
      checkFlag("cont2 rsp1_valid", bus.rsp1_valid, 1'b1);
      checkFlag("cont2 rsp0_valid", bus.rsp0_valid, 1'b0);
      checkOutput("cont2 result", bus.rsp1_result, 32'hFFFF_FFFF);
      checkFlag("cont2 err", bus.rsp1_err, 1'b0);
      stepToDrive();
      stepToSample();
      checkFlag("cont3 ready0", bus.req0_ready, 1'b1);
      checkFlag("cont3 ready1", bus.req1_ready, 1'b0);
      stepToDrive();
      applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'b0000);
      applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'b0000);
      stepToSample();
      stepToDrive();
      stepToSample();
      checkFlag("cont3 rsp0_valid", bus.rsp0_valid, 1'b1);
      checkOutput("cont3 result", bus.rsp0_result, 32'hF000_F000);
      stepToDrive();
      stepToSample();
      checkFlag("cont3 idle busy", busy, 1'b0);

      // Table of lone transactions.
      for (int i = 0; i < 7; i++) begin
         runVector(vecs[i], i);
      end

      // Response stall on port 0 while port 1 keeps requesting.
      stepToDrive();
      applyStimulus(0, 1'b1, 32'h0F0F_0F0F, 32'h00FF_00FF, 4'b0110);
      bus.rsp0_ready = 1'b0;
      stepToSample();
      checkFlag("stall accept ready0", bus.req0_ready, 1'b1);
      stepToDrive();
      applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'b0000);
      applyStimulus(1, 1'b1, 32'h0000_00FF, 32'h0000_0F00, 4'b0101);
      bus.rsp1_ready = 1'b1;
      stepToSample();
      checkFlag("stall exec ready1", bus.req1_ready, 1'b0);
      for (int i = 0; i < 5; i++) begin
         stepToDrive();
         stepToSample();
         checkFlag($sformatf("stall%0d rsp0_valid", i), bus.rsp0_valid, 1'b1);
         checkOutput($sformatf("stall%0d result", i), bus.rsp0_result, 32'h0FF0_0FF0);
         checkFlag($sformatf("stall%0d busy", i), busy, 1'b1);
         checkFlag($sformatf("stall%0d ready1", i), bus.req1_ready, 1'b0);
      end
      stepToDrive();
      bus.rsp0_ready = 1'b1;
      stepToSample();
      checkFlag("stall release rsp0_valid", bus.rsp0_valid, 1'b1);
      stepToDrive();
      stepToSample();
      checkFlag("stall done busy", busy, 1'b0);
      checkFlag("stall done rsp0_valid", bus.rsp0_valid, 1'b0);
      checkFlag("stall done ready1", bus.req1_ready, 1'b1);
      stepToDrive();
      applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'b0000);
      stepToSample();
      stepToDrive();
      stepToSample();
      checkFlag("stall port1 rsp_valid", bus.rsp1_valid, 1'b1);
      checkOutput("stall port1 result", bus.rsp1_result, 32'h0000_0FFF);
      stepToDrive();
      stepToSample();

      // Serve port 0 so prio points at port 1, then reset during EXEC.
      runVector(vecs[1], 10);
      stepToDrive();
      applyStimulus(1, 1'b1, 32'hFFFF_0000, 32'h0000_FFFF, 4'b0101);
      stepToSample();
      checkFlag("rstexec ready1", bus.req1_ready, 1'b1);
      stepToDrive();
      applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'b0000);
      rst_n = 1'b0;
      stepToSample();
      checkFlag("rstexec exec busy", busy, 1'b1);
      checkFlag("rstexec exec rsp1_valid", bus.rsp1_valid, 1'b0);
      stepToDrive();
      rst_n = 1'b1;
      applyStimulus(0, 1'b1, 32'hFFFF_FFFF, 32'h0000_FFFF, 4'b0100);
      applyStimulus(1, 1'b1, 32'h1111_1111, 32'h2222_2222, 4'b0101);
      stepToSample();
      checkFlag("rstexec idle busy", busy, 1'b0);
      checkFlag("rstexec no rsp1_valid", bus.rsp1_valid, 1'b0);
      checkOutput("rstexec result cleared", bus.rsp1_result, 32'h0);
      checkFlag("rstexec prio0 ready0", bus.req0_ready, 1'b1);
      checkFlag("rstexec prio0 ready1", bus.req1_ready, 1'b0);
      stepToDrive();
      applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'b0000);
      applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'b0000);
      stepToSample();
      checkFlag("rstexec later rsp1_valid", bus.rsp1_valid, 1'b0);
      stepToDrive();
      stepToSample();
      checkFlag("rstexec port0 rsp_valid", bus.rsp0_valid, 1'b1);
      checkFlag("rstexec port0 no rsp1", bus.rsp1_valid, 1'b0);
      checkOutput("rstexec port0 result", bus.rsp0_result, 32'h0000_FFFF);
      stepToDrive();
      stepToSample();

      // Random back-to-back traffic with both ports always valid.
      prioModel = 1'b1;
      for (int p = 0; p < 2; p++) begin
         pending[p]  = 1'b0;
         waitCnt[p]  = 0;
         stallCnt[p] = 0;
         expRes[p]   = 32'h0;
         expErr[p]   = 1'b0;
      end
      stepToDrive();
      newRandomReq(0);
      newRandomReq(1);
      bus.rsp0_ready = ($urandom_range(0, 3) != 0);
      bus.rsp1_ready = ($urandom_range(0, 3) != 0);
      for (int cyc = 0; cyc < 400; cyc++) begin
         stepToSample();
         waitCnt[0]++;
         waitCnt[1]++;
         if ((bus.rsp0_valid && !bus.rsp0_ready) || (bus.rsp1_valid && !bus.rsp1_ready)) begin
            stallCnt[0]++;
            stallCnt[1]++;
         end
         acc[0] = bus.req0_valid && bus.req0_ready;
         acc[1] = bus.req1_valid && bus.req1_ready;
         if (acc[0] || acc[1]) begin
            checkFlag("rnd grant port", acc[1], prioModel);
            checkFlag("rnd single grant", acc[0] && acc[1], 1'b0);
         end
         for (int p = 0; p < 2; p++) begin
            if (acc[p]) begin
               checkFlag($sformatf("rnd wait bound p%0d", p),
                         (waitCnt[p] <= 6 + stallCnt[p]), 1'b1);
               checkFlag($sformatf("rnd no double issue p%0d", p), pending[p], 1'b0);
               modelOut    = modelAlu(rOp[p], rA[p], rB[p]);
               expRes[p]   = modelOut[31:0];
               expErr[p]   = modelOut[32];
               pending[p]  = 1'b1;
               waitCnt[p]  = 0;
               stallCnt[p] = 0;
            end
         end
         checkFlag("rnd exclusive rsp_valid", bus.rsp0_valid && bus.rsp1_valid, 1'b0);
         if (bus.rsp0_valid && bus.rsp0_ready) begin
            checkFlag("rnd rsp0 expected", pending[0], 1'b1);
            checkOutput("rnd rsp0 result", bus.rsp0_result, expRes[0]);
            checkFlag("rnd rsp0 err", bus.rsp0_err, expErr[0]);
            pending[0] = 1'b0;
            prioModel  = 1'b1;
         end
         if (bus.rsp1_valid && bus.rsp1_ready) begin
            checkFlag("rnd rsp1 expected", pending[1], 1'b1);
            checkOutput("rnd rsp1 result", bus.rsp1_result, expRes[1]);
            checkFlag("rnd rsp1 err", bus.rsp1_err, expErr[1]);
            pending[1] = 1'b0;
            prioModel  = 1'b0;
         end
         stepToDrive();
         for (int p = 0; p < 2; p++) begin
            if (acc[p]) begin
               newRandomReq(p);
            end
         end
         bus.rsp0_ready = ($urandom_range(0, 3) != 0);
         bus.rsp1_ready = ($urandom_range(0, 3) != 0);
      end

      // Drain whatever is in flight and confirm the block goes idle.
      applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'b0000);
      applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'b0000);
      bus.rsp0_ready = 1'b1;
      bus.rsp1_ready = 1'b1;
      repeat (4) stepToDrive();
      stepToSample();
      checkFlag("drain busy", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
